hub75_scan_ctrl: RTL and testbench

- Sequencer for the HUB75 RGB LED matrix (64x32, 1/16 scan) at the display end of the audio spectrum path.
- Fetches 64 five-bit column heights from the plot buffer through a synchronous read port.
- Shifts the matching bar-graph pixels out on R1/G1/B1/R2/G2/B2, then latches, selects the row and gates OE, row pair by row pair.
- Pulses frame_start so the FFT-side writer can update the plot buffer between frames.

---
 rtl/hub75_pkg.sv | 28 ++
 rtl/hub75_scan_ctrl_if.sv | 20 ++
 rtl/hub75_pixel_colour.sv | 29 ++
 rtl/hub75_scan_ctrl.sv | 107 ++++++++++
 tb/tb_hub75_scan_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// Shared types and geometry for the HUB75 64x32 1/16-scan panel sequencer.
package hub75_pkg;

   localparam int COLS    = 64;
   localparam int ROWS    = 32;
   localparam int SCAN    = 16;
   localparam int RED_END = 8;
   localparam int YEL_END = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH0,
      ST_FETCH1,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_BLANK_PRE,
      ST_LATCH,
      ST_BLANK_POST,
      ST_DISPLAY
   } state_t;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Plot buffer read port plus the HUB75 panel pins, as seen by the scan sequencer.
interface hub75_scan_ctrl_if;
   logic [5:0] col_addr;
   logic [4:0] col_height;
   logic       R1, G1, B1, R2, G2, B2;
   logic       A, B, C, D;
   logic       LATCH, CLK_OUT, OE, frame_start;

   modport master (
      output col_addr, input col_height,
      output R1, G1, B1, R2, G2, B2,
      output A, B, C, D, LATCH, CLK_OUT, OE, frame_start
   );

   modport slave (
      input col_addr, output col_height,
      input R1, G1, B1, R2, G2, B2,
      input A, B, C, D, LATCH, CLK_OUT, OE, frame_start
   );
endinterface

// File: rtl/hub75_pixel_colour.sv
// Bar-graph pixel colour: lit when y reaches into the bar of height h, banded red/yellow/green by y.
module hub75_pixel_colour
   import hub75_pkg::*;
(
   input  logic [4:0] y,
   input  logic [4:0] h,
   output rgb_t       rgb
);
   logic [5:0] sum;
   logic       lit;

   // y >= 32-h rewritten as y+h >= 32 so h=0 never lights anything
   assign sum = {1'b0, y} + {1'b0, h};
   assign lit = (sum >= 6'(ROWS));

   always_comb begin
      rgb = '0;
      if (lit) begin
         if (y < 5'(RED_END)) begin
            rgb.r = 1'b1;
         end else if (y < 5'(YEL_END)) begin
            rgb.r = 1'b1;
            rgb.g = 1'b1;
         end else begin
            rgb.g = 1'b1;
         end
      end
   end
endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: fetch column heights, shift bar pixels, blank/latch/select row, then display.
module hub75_scan_ctrl
   import hub75_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int BLANK_CYC = 4,
   parameter int ON_CYC    = 1024
) (
   input  logic                MCLK,
   input  logic                reset,
   input  logic                enable,
   hub75_scan_ctrl_if.master   bus
);
   state_t      state, state_nxt;
   logic [5:0]  col;
   logic [3:0]  row, sel;
   logic [15:0] cnt, phase_len;
   logic        last, fs_set, clk_out, latch, oe;
   rgb_t        top_rgb, bot_rgb, top_q, bot_q;

   hub75_pixel_colour u_top (.y({1'b0, row}), .h(bus.col_height), .rgb(top_rgb));
   hub75_pixel_colour u_bot (.y({1'b1, row}), .h(bus.col_height), .rgb(bot_rgb));

   always_comb begin
      state_nxt = state;
      phase_len = 16'd1;
      clk_out   = 1'b0;
      latch     = 1'b0;
      oe        = 1'b1;
      case (state)
         ST_SHIFT_LO, ST_SHIFT_HI:    phase_len = 16'(CLK_DIV);
         ST_BLANK_PRE, ST_BLANK_POST: phase_len = 16'(BLANK_CYC);
         ST_DISPLAY:                  phase_len = 16'(ON_CYC);
         default:                     phase_len = 16'd1;
      endcase
      last = (cnt == phase_len - 16'd1);
      case (state)
         ST_IDLE:       if (enable) state_nxt = ST_FETCH0;
         ST_FETCH0:     state_nxt = ST_FETCH1;
         ST_FETCH1:     state_nxt = ST_SHIFT_LO;
         ST_SHIFT_LO:   if (last) state_nxt = ST_SHIFT_HI;
         ST_SHIFT_HI: begin
            clk_out = 1'b1;
            if (last) state_nxt = (col == 6'(COLS - 1)) ? ST_BLANK_PRE : ST_FETCH0;
         end
         ST_BLANK_PRE:  if (last) state_nxt = ST_LATCH;
         ST_LATCH: begin
            latch     = 1'b1;
            state_nxt = ST_BLANK_POST;
         end
         ST_BLANK_POST: if (last) state_nxt = ST_DISPLAY;
         ST_DISPLAY: begin
            oe = 1'b0;
            if (last) state_nxt = enable ? ST_FETCH0 : ST_IDLE;
         end
         default:       state_nxt = ST_IDLE;
      endcase
      // frame boundary: row pair 0 starts either from idle or after row 15 wraps
      fs_set = (state_nxt == ST_FETCH0) &&
               (((state == ST_IDLE) && (row == 4'd0)) ||
                ((state == ST_DISPLAY) && (row == 4'(SCAN - 1))));
   end

   always_ff @(posedge MCLK or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         col   <= '0;
         row   <= '0;
         sel   <= '0;
         top_q <= '0;
         bot_q <= '0;
         bus.frame_start <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= ((state_nxt != state) || (state == ST_IDLE)) ? 16'd0 : cnt + 16'd1;
         bus.frame_start <= fs_set;
         if (state == ST_FETCH1) begin
            top_q <= top_rgb;
            bot_q <= bot_rgb;
         end
         if ((state == ST_SHIFT_HI) && last) begin
            if (col == 6'(COLS - 1)) sel <= row;
            else                     col <= col + 6'd1;
         end
         if ((state == ST_DISPLAY) && last) begin
            col <= '0;
            row <= row + 4'd1;
         end
      end
   end

   assign bus.col_addr = col;
   assign bus.R1       = top_q.r;
   assign bus.G1       = top_q.g;
   assign bus.B1       = top_q.b;
   assign bus.R2       = bot_q.r;
   assign bus.G2       = bot_q.g;
   assign bus.B2       = bot_q.b;
   assign bus.A        = sel[0];
   assign bus.B        = sel[1];
   assign bus.C        = sel[2];
   assign bus.D        = sel[3];
   assign bus.CLK_OUT  = clk_out;
   assign bus.LATCH    = latch;
   assign bus.OE       = oe;
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: row-pair counts, bar pixels, enable drop and async reset.
module tb_hub75_scan_ctrl;
   localparam int CLK_DIV   = 2;
   localparam int BLANK_CYC = 4;
   localparam int ON_CYC    = 40;
   localparam int ROW_CYC   = 64 * (2 + 2 * CLK_DIV) + 2 * BLANK_CYC + 1 + ON_CYC;

   logic MCLK = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   pat = 0;

   hub75_scan_ctrl_if bus ();

   hub75_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .ON_CYC(ON_CYC)) dut (
      .MCLK(MCLK), .reset(reset), .enable(enable), .bus(bus)
   );

   always #5 MCLK = ~MCLK;

   function automatic logic [4:0] hgt(int p, int c);
      case (p)
         0:       return 5'd31;
         1:       return 5'(c % 32);
         2:       return 5'((c * 7 + 3) % 32);
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [2:0] colour(int y, int h);
      if (y < 32 - h) return 3'b000;
      if (y < 8)      return 3'b100;
      if (y < 16)     return 3'b110;
      return 3'b010;
   endfunction

   function automatic logic [5:0] exp_pix(int r, int h);
      return {colour(r, h), colour(r + 16, h)};
   endfunction

   // synchronous plot buffer model
   always @(posedge MCLK) bus.col_height <= hgt(pat, int'(bus.col_addr));

   int         rises = 0, latches = 0, on_cnt = 0, early = 0, overlap = 0, fs_cnt = 0;
   int         rows_done = 0;
   int         s_rises = 0, s_latches = 0, s_on = 0, s_early = 0, s_overlap = 0, s_fs = 0;
   logic [3:0] abcd = '0, s_abcd = '0;
   logic [5:0] pix [64];
   logic [5:0] s_pix [64];
   logic       prev_clk = 1'b0, prev_oe = 1'b1;

   always @(negedge MCLK) begin
      if (!reset) begin
         rises = 0; latches = 0; on_cnt = 0; early = 0; overlap = 0; fs_cnt = 0;
         prev_clk = 1'b0; prev_oe = 1'b1;
      end else begin
         if (bus.OE && !prev_oe) begin
            s_rises = rises; s_latches = latches; s_on = on_cnt; s_early = early;
            s_overlap = overlap; s_fs = fs_cnt; s_abcd = abcd; s_pix = pix;
            rows_done++;
            rises = 0; latches = 0; on_cnt = 0; early = 0; overlap = 0; fs_cnt = 0;
         end
         if (bus.CLK_OUT && !prev_clk) begin
            if (rises < 64) pix[rises] = {bus.R1, bus.G1, bus.B1, bus.R2, bus.G2, bus.B2};
            rises++;
         end
         if (bus.LATCH) begin
            latches++;
            abcd = {bus.D, bus.C, bus.B, bus.A};
            if (bus.CLK_OUT) overlap++;
         end
         if (!bus.OE) begin
            on_cnt++;
            if (latches == 0) early++;
         end
         if (bus.frame_start) fs_cnt++;
         prev_clk = bus.CLK_OUT;
         prev_oe  = bus.OE;
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge MCLK);
   endtask

   task automatic wait_latch();
      int k = 0;
      while (!bus.LATCH && k < 2 * ROW_CYC) begin
         @(negedge MCLK);
         k++;
      end
      chk("latch_seen", 32'(bus.LATCH), 32'd1);
   endtask

   task automatic wait_rows();
      int tgt = rows_done + 1;
      int k = 0;
      while (rows_done < tgt && k < 2 * ROW_CYC) begin
         @(negedge MCLK);
         k++;
      end
      chk("row_done", 32'(rows_done >= tgt), 32'd1);
   endtask

   // next_pat takes effect for the row pair after this one
   task automatic run_row(int r, int fs, int next_pat);
      int used;
      int nb = 0;
      wait_latch();
      used = pat;
      pat  = next_pat;
      wait_rows();
      chk($sformatf("r%0d_rises", r),   32'(s_rises),   32'd64);
      chk($sformatf("r%0d_latch", r),   32'(s_latches), 32'd1);
      chk($sformatf("r%0d_abcd", r),    32'(s_abcd),    32'(r));
      chk($sformatf("r%0d_on", r),      32'(s_on),      32'(ON_CYC));
      chk($sformatf("r%0d_early", r),   32'(s_early),   32'd0);
      chk($sformatf("r%0d_overlap", r), 32'(s_overlap), 32'd0);
      chk($sformatf("r%0d_fs", r),      32'(s_fs),      32'(fs));
      for (int c = 0; c < 64; c++)
         if (s_pix[c] !== exp_pix(r, int'(hgt(used, c)))) nb++;
      chk($sformatf("r%0d_pix", r), 32'(nb), 32'd0);
   endtask

   task automatic chk_reset_vals(string pfx);
      chk({pfx, "_oe"},    32'(bus.OE),          32'd1);
      chk({pfx, "_clk"},   32'(bus.CLK_OUT),     32'd0);
      chk({pfx, "_latch"}, 32'(bus.LATCH),       32'd0);
      chk({pfx, "_fs"},    32'(bus.frame_start), 32'd0);
      chk({pfx, "_addr"},  32'(bus.col_addr),    32'd0);
      chk({pfx, "_pix"},   32'({bus.R1, bus.G1, bus.B1, bus.R2, bus.G2, bus.B2}), 32'd0);
      chk({pfx, "_sel"},   32'({bus.D, bus.C, bus.B, bus.A}), 32'd0);
   endtask

   initial begin
      int k;
      enable = 1'b1;
      tick(3);
      chk_reset_vals("rst");

      reset = 1'b1;
      k = 0;
      while (!bus.frame_start && k < 10) begin tick(1); k++; end
      chk("fs_after_reset", 32'(bus.frame_start), 32'd1);
      k = 0;
      while (!bus.CLK_OUT && k < 20) begin tick(1); k++; end
      chk("first_rise_delay", 32'(k), 32'd4);

      run_row(0, 1, 0);
      chk("r0_col0", 32'(s_pix[0]),  32'b000010);
      chk("r0_col63", 32'(s_pix[63]), 32'b000010);
      run_row(1, 0, 0);
      run_row(2, 0, 0);
      run_row(3, 0, 1);
      run_row(4, 0, 0);
      chk("r4_c28_R1", 32'(s_pix[28][5]), 32'd1);
      chk("r4_c27_R1", 32'(s_pix[27][5]), 32'd0);
      chk("r4_c12_G2", 32'(s_pix[12][1]), 32'd1);
      chk("r4_c11_G2", 32'(s_pix[11][1]), 32'd0);
      run_row(5, 0, 0);
      run_row(6, 0, 0);
      run_row(7, 0, 0);
      run_row(8, 0, 2);
      chk("r8_col5", 32'(s_pix[5]), 32'b110010);
      for (int r = 9; r < 15; r++) run_row(r, 0, 2);
      run_row(15, 0, 3);
      run_row(0, 1, 1);
      for (int r = 1; r < 5; r++) run_row(r, 0, 1);

      // row 5 is now shifting; drop enable mid-row
      tick(20);
      enable = 1'b0;
      run_row(5, 0, 1);
      tick(50);
      chk("idle_oe",    32'(bus.OE),      32'd1);
      chk("idle_clk",   32'(bus.CLK_OUT), 32'd0);
      chk("idle_rises", 32'(rises),       32'd0);
      chk("idle_on",    32'(on_cnt),      32'd0);
      chk("idle_fs",    32'(fs_cnt),      32'd0);
      enable = 1'b1;
      run_row(6, 0, 1);

      k = 0;
      while (bus.OE && k < 2 * ROW_CYC) begin tick(1); k++; end
      chk("display_seen", 32'(bus.OE), 32'd0);
      tick(5);
      reset = 1'b0;
      #1;
      chk_reset_vals("midrst");
      tick(2);
      reset = 1'b1;
      run_row(0, 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end
endmodule
